// File: rtl/gray_counter_nbit_if.sv
// Bundle between the button pulse generator and the Gray counter.
// The master side drives count requests; the slave side returns the count.
interface gray_counter_nbit_if #(
    parameter int N = 4
);
    logic         pulse;
    logic         up;
    logic         clear;
    logic [N-1:0] bin;
    logic [N-1:0] gray;
    logic         wrap;
    logic         stuck;

    modport master (
        output pulse,
        output up,
        output clear,
        input  bin,
        input  gray,
        input  wrap,
        input  stuck
    );

    modport slave (
        input  pulse,
        input  up,
        input  clear,
        output bin,
        output gray,
        output wrap,
        output stuck
    );
endinterface

// File: rtl/gray_counter_nbit.sv
// Up/down counter with binary and registered Gray outputs, fed by
// single-cycle pulses; an edge qualifier stops long pulses double-counting.
module gray_counter_nbit #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    gray_counter_nbit_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [N-1:0] ONE = N'(1);

    state_t       state_q, state_d;
    logic [N-1:0] bin_q, bin_d;
    logic [N-1:0] gray_q, gray_d;
    logic         wrap_q, wrap_d;
    logic         stuck_q, stuck_d;
    logic         accept;

    // Qualify the pulse edge and compute the next count and flags.
    always_comb begin
        state_d = state_q;
        stuck_d = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.pulse) begin
                    accept  = 1'b1;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (bus.pulse) begin
                    stuck_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (bus.clear) begin
            // A pulse seen here still arms the FSM, so it is swallowed.
            bin_d = '0;
        end else if (accept) begin
            if (bus.up) begin
                bin_d  = bin_q + ONE;
                wrap_d = (bin_q == '1);
            end else begin
                bin_d  = bin_q - ONE;
                wrap_d = (bin_q == '0);
            end
        end

        // Gray is derived from the next binary value so both flop together.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    // State, count and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            gray_q  <= '0;
            wrap_q  <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            wrap_q  <= wrap_d;
            stuck_q <= stuck_d;
        end
    end

    assign bus.bin   = bin_q;
    assign bus.gray  = gray_q;
    assign bus.wrap  = wrap_q;
    assign bus.stuck = stuck_q;

endmodule

// File: tb/tb_gray_counter_nbit.sv
// Directed bench for the 4-bit Gray counter: vector tables for
// single-cycle sequences, hand-written loops for the multi-cycle cases.
module tb_gray_counter_nbit;

    localparam int N = 4;

    typedef struct {
        logic       p;
        logic       u;
        logic       c;
        logic [3:0] eb;
        logic [3:0] eg;
        logic       ew;
        logic       es;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    gray_counter_nbit_if #(.N(N)) bus ();

    gray_counter_nbit #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   nvec = 0;
    int   nbad = 0;
    vec_t tbl[$];

    task automatic check(input string nm, input logic [3:0] eb,
                         input logic [3:0] eg, input logic ew,
                         input logic es);
        nvec++;
        if (bus.bin !== eb || bus.gray !== eg ||
            bus.wrap !== ew || bus.stuck !== es) begin
            nbad++;
            $display("FAIL %s: got bin=%b gray=%b wrap=%b stuck=%b, want bin=%b gray=%b wrap=%b stuck=%b",
                     nm, bus.bin, bus.gray, bus.wrap, bus.stuck,
                     eb, eg, ew, es);
        end
    endtask

    task automatic step(input logic p, input logic u, input logic c);
        @(negedge clk);
        bus.pulse = p;
        bus.up    = u;
        bus.clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string nm);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].p, tbl[i].u, tbl[i].c);
            check($sformatf("%s[%0d]", nm, i), tbl[i].eb, tbl[i].eg,
                  tbl[i].ew, tbl[i].es);
        end
        tbl.delete();
    endtask

    function automatic logic [3:0] g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        logic [3:0] b;
        bus.pulse = 1'b0;
        bus.up    = 1'b1;
        bus.clear = 1'b0;

        // Asynchronous reset mid-cycle, then hold.
        #2 rst = 1'b1;
        #1 check("reset_async", 4'd0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check("reset_hold", 4'd0, 4'd0, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Five single-cycle up pulses spaced 3 cycles.
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd1, 4'b0001, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'd1, 4'b0001, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'd1, 4'b0001, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd2, 4'b0011, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'd2, 4'b0011, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 4'd2, 4'b0011, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd3, 4'b0010, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 4'd3, 4'b0010, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'd3, 4'b0010, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd4, 4'b0110, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'd4, 4'b0110, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'd4, 4'b0110, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd5, 4'b0111, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'd5, 4'b0111, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'd5, 4'b0111, 1'b0, 1'b0});
        run_table("up5");

        // Held pulse, three times: one count each, stuck from 2nd cycle.
        for (int r = 0; r < 3; r++) begin
            b = 4'(6 + r);
            for (int c = 1; c <= 10; c++) begin
                step(1'b1, 1'b1, 1'b0);
                check($sformatf("held%0d_c%0d", r, c), b, g(b), 1'b0,
                      (c >= 2) ? 1'b1 : 1'b0);
            end
            step(1'b0, 1'b1, 1'b0);
            check($sformatf("held%0d_fall", r), b, g(b), 1'b0, 1'b0);
        end
        check("held_final", 4'b1000, 4'b1100, 1'b0, 1'b0);

        // Wrap upward after 16 pulses, then wrap downward.
        step(1'b0, 1'b1, 1'b1);
        check("wrap_clear", 4'd0, 4'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            b = 4'(k);
            step(1'b1, 1'b1, 1'b0);
            check($sformatf("wrapup_p%0d", k), b, g(b),
                  (k == 16) ? 1'b1 : 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            check($sformatf("wrapup_g%0d", k), b, g(b), 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0);
        check("wrapdn_p", 4'b1111, 4'b1000, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("wrapdn_g", 4'b1111, 4'b1000, 1'b0, 1'b0);

        // Clear coincident with pulse: pulse consumed, not replayed.
        tbl.push_back('{1'b0, 1'b1, 1'b1, 4'd0, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd1, 4'b0001, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'd1, 4'b0001, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd2, 4'b0011, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'd2, 4'b0011, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd3, 4'b0010, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'd3, 4'b0010, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 4'd0, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd1, 4'b0001, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'd1, 4'b0001, 1'b0, 1'b0});
        run_table("clr");

        // Maximum pulse rate: 1,0,1,0 for 20 cycles.
        step(1'b0, 1'b1, 1'b1);
        check("max_clear", 4'd0, 4'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            b = 4'(i);
            step(1'b1, 1'b1, 1'b0);
            check($sformatf("max_p%0d", i), b, g(b), 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0);
            check($sformatf("max_g%0d", i), b, g(b), 1'b0, 1'b0);
        end
        check("max_final", 4'b1010, 4'b1111, 1'b0, 1'b0);

        // Reset while ARMED with pulse held, released with pulse high.
        step(1'b1, 1'b1, 1'b0);
        check("arm_count", 4'd11, 4'b1110, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("arm_stuck", 4'd11, 4'b1110, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1 check("rst_mid", 4'd0, 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 check("rst_mid_hold", 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("rst_release", 4'd1, 4'b0001, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("rst_rel_stuck", 4'd1, 4'b0001, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        check("rst_rel_fall", 4'd1, 4'b0001, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
